// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  // Width of an iteration counter that has to reach w-1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division trial subtract: diff = a - b over N bits, borrow=1 when a < b.
// Built as a + ~b + 1 with per-bit propagate/generate terms and a ripple carry.
module div_sub_step #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N-1:0] p;
  logic [N-1:0] g;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pg
      assign p[gi] = a[gi] ^ ~b[gi];
      assign g[gi] = a[gi] & ~b[gi];
    end
  endgenerate

  // Ripple the carry from the +1 injected at bit 0; no final carry means a borrow.
  always_comb begin : carry_chain
    logic cy;
    cy = 1'b1;
    for (int i = 0; i < N; i++) begin
      diff[i] = p[i] ^ cy;
      cy      = g[i] | (p[i] & cy);
    end
    borrow = ~cy;
  end

endmodule

// File: rtl/seq_div16.sv
// Iterative restoring divider, one quotient bit per clock, ready/valid on both sides.
// Optional build macro DIV_SIGNED_EN: two's-complement operands, truncating division
// (core runs on magnitudes, sign fix-up applied when the last step enters DONE).
module seq_div16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH:0]   r_reg, r_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dz_reg, dz_next;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // After every step R < divisor, so its top bit is always 0 and never read back.
  logic unused_rtop;
  assign unused_rtop = r_reg[WIDTH];

  assign trial = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

  div_sub_step #(.N(WIDTH + 1)) u_sub (
    .a      (trial),
    .b      ({1'b0, dvs_reg}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign step_r = borrow ? trial : diff;
  assign step_q = {q_reg[WIDTH-2:0], ~borrow};

`ifdef DIV_SIGNED_EN
  logic qneg_reg, qneg_next;
  logic rneg_reg, rneg_next;

  // Magnitudes feed the unsigned core; the most-negative value maps onto itself, which is its magnitude.
  always_comb begin
    dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    quot_fix = qneg_reg ? -step_q : step_q;
    rem_fix  = rneg_reg ? -step_r[WIDTH-1:0] : step_r[WIDTH-1:0];
  end

  // Sign flags captured at acceptance: quotient negative on differing signs, remainder follows dividend.
  always_ff @(posedge clk) begin
    if (rst) begin
      qneg_reg <= 1'b0;
      rneg_reg <= 1'b0;
    end else begin
      qneg_reg <= qneg_next;
      rneg_reg <= rneg_next;
    end
  end

  // Flags load only on a non-zero-divisor acceptance.
  always_comb begin
    qneg_next = qneg_reg;
    rneg_next = rneg_reg;
    if (state_reg == IDLE && in_valid && divisor != '0) begin
      qneg_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_next = dividend[WIDTH-1];
    end
  end
`else
  // Unsigned core: operands and results pass straight through.
  always_comb begin
    dvd_mag  = dividend;
    dvs_mag  = divisor;
    quot_fix = step_q;
    rem_fix  = step_r[WIDTH-1:0];
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      dvs_reg   <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      r_reg     <= r_next;
      q_reg     <= q_next;
      dvs_reg   <= dvs_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dz_reg    <= dz_next;
    end
  end

  // Next-state and datapath: accept, iterate WIDTH steps, then hold the result until consumed.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    r_next     = r_reg;
    q_next     = q_reg;
    dvs_next   = dvs_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dz_next    = dz_reg;
    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_next = DONE;
            quot_next  = '1;
            rem_next   = dividend;
            dz_next    = 1'b1;
          end else begin
            state_next = CALC;
            dvs_next   = dvs_mag;
            q_next     = dvd_mag;
            r_next     = '0;
            cnt_next   = '0;
            dz_next    = 1'b0;
          end
        end
      end
      CALC: begin
        r_next   = step_r;
        q_next   = step_q;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          state_next = DONE;
          quot_next  = quot_fix;
          rem_next   = rem_fix;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign quot      = quot_reg;
  assign rem       = rem_reg;
  assign div_zero  = dz_reg;

endmodule

// File: tb/tb_seq_div16.sv
// Directed bench for seq_div16 with a result scoreboard; honours DIV_SIGNED_EN.
module tb_seq_div16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        div_zero;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_div16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic [15:0] dvd, input logic [15:0] dvs);
    exp_t e;
    int   sa, sd;
    sa = 0;
    sd = 0;
    if (dvs == 16'd0) begin
      e.q  = 16'hFFFF;
      e.r  = dvd;
      e.dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa   = int'($signed(dvd));
      sd   = int'($signed(dvs));
      e.q  = 16'(sa / sd);
      e.r  = 16'(sa % sd);
`else
      sa   = int'(dvd);
      sd   = int'(dvs);
      e.q  = 16'(sa / sd);
      e.r  = 16'(sa % sd);
`endif
      e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_quot_rem_dz"}, {quot, rem, div_zero}, 33'd0);
  endtask

  // One full transaction: accept, time the result, score it, optionally stall, then consume.
  task automatic run_div(input logic [15:0] dvd, input logic [15:0] dvs, input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (!in_ready && lat < 40) begin
      tick();
      lat++;
    end
    check("in_ready_before_accept", in_ready, 1);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    push_model(dvd, dvs);
    tick();
    in_valid = 1'b0;
    // Operands are latched at acceptance, so later input changes must not matter.
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    // Edges after the acceptance edge until OUT_VALID is seen.
    check("latency", lat, (dvs == 16'd0) ? 0 : 16);
    e.q  = 16'hxxxx;
    e.r  = 16'hxxxx;
    e.dz = 1'bx;
    if (sb.size() == 0) check("scoreboard_nonempty", 0, 1);
    else e = sb.pop_front();
    check("quot", quot, e.q);
    check("rem", rem, e.r);
    check("div_zero", div_zero, e.dz);
    check("in_ready_in_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_stable", {out_valid, in_ready, quot, rem, div_zero}, {1'b1, 1'b0, e.q, e.r, e.dz});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("after_handshake", {out_valid, in_ready}, 2'b01);
    $display("div 0x%04h / 0x%04h -> quot 0x%04h rem 0x%04h dz %0b lat %0d hold %0d",
             dvd, dvs, e.q, e.r, e.dz, lat, hold);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) tick();
    check_reset_state("reset_held");
    rst = 1'b0;
    tick();
    check_reset_state("reset_released");

    run_div(16'd100, 16'd7, 0);
    run_div(16'hFFFF, 16'h0001, 0);
    run_div(16'h0005, 16'h0009, 0);
    run_div(16'd1234, 16'd0, 0);
    run_div(16'h0FFF, 16'h0013, 10);
    run_div(16'hFFFF, 16'hFFFF, 0);
    run_div(16'h0000, 16'h0005, 0);
    run_div(16'hFFF9, 16'h0002, 0);
    run_div(16'h8000, 16'hFFFF, 0);
    run_div(16'h7FFF, 16'h8000, 0);
    for (int i = 0; i < 6; i++) begin
      run_div(16'($urandom), 16'($urandom_range(1, 16'hFFFF)), 0);
    end

    // Abort a division at step 8 with reset: no result may appear.
    dividend = 16'd1000;
    divisor  = 16'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("reset_abort");
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("no_out_after_abort", seen, 0);
    $display("abort 0x%04h / 0x%04h at step 8 -> no result", 16'd1000, 16'd3);
    run_div(16'd50, 16'd5, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
